// File: rtl/qq_tail_if.sv
// Handshake bundle between the last QuickQ node and the tail responder.
interface qq_tail_if #(
    parameter int W = 32,
    parameter int T = 4
);
    localparam int CW = $clog2(T + 1);

    logic          enq_i;
    logic [W-1:0]  data_lt_i;
    logic          deq_i;
    logic [W-1:0]  data_rt_o;
    logic          busy;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          drop;
    logic          overflow;

    // Chain side: pushes keys and pops the minimum.
    modport master (
        output enq_i, data_lt_i, deq_i,
        input  data_rt_o, busy, count, full, empty, drop, overflow
    );

    // Tail side: absorbs keys and presents its minimum.
    modport slave (
        input  enq_i, data_lt_i, deq_i,
        output data_rt_o, busy, count, full, empty, drop, overflow
    );
endinterface

// File: rtl/qq_tail.sv
// QuickQ tail: sorted register store terminating a node chain.
// Insertion scans one slot per cycle; dequeue shifts all slots down at once.
module qq_tail #(
    parameter int           W       = 32,
    parameter int           T       = 4,
    parameter logic [W-1:0] MAX_KEY = '1
) (
    input  logic   clk,
    input  logic   rst,
    qq_tail_if.slave bus
);
    localparam int CW = $clog2(T + 1);
    localparam int IW = $clog2(T);
    localparam logic [CW-1:0] FULL_CNT = CW'(T);

    typedef enum logic {IDLE, INS} state_t;

    state_t        state_q;
    logic [W-1:0]  slot_q [T];
    logic [W-1:0]  temp_q;
    logic [IW-1:0] idx_q;
    logic [CW-1:0] count_q;
    logic          drop_q;
    logic          overflow_q;

    // Tail FSM: accept pushes, run the insertion scan, shift on pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            for (int unsigned i = 0; i < T; i++) begin
                slot_q[i] <= MAX_KEY;
            end
            temp_q     <= MAX_KEY;
            idx_q      <= '0;
            count_q    <= '0;
            drop_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.enq_i) begin
                        // Sentinel keys are silently ignored; enq beats deq.
                        if (bus.data_lt_i != MAX_KEY) begin
                            if (count_q == FULL_CNT) begin
                                drop_q     <= 1'b1;
                                overflow_q <= 1'b1;
                            end else begin
                                temp_q  <= bus.data_lt_i;
                                idx_q   <= '0;
                                state_q <= INS;
                            end
                        end
                    end else if (bus.deq_i && (count_q != '0)) begin
                        for (int unsigned i = 0; i < T - 1; i++) begin
                            slot_q[i] <= slot_q[i+1];
                        end
                        slot_q[T-1] <= MAX_KEY;
                        count_q     <= count_q - CW'(1);
                    end
                end
                INS: begin
                    // Strict compare keeps equal keys in arrival order.
                    if (slot_q[idx_q] == MAX_KEY) begin
                        slot_q[idx_q] <= temp_q;
                        count_q       <= count_q + CW'(1);
                        state_q       <= IDLE;
                    end else if (temp_q < slot_q[idx_q]) begin
                        slot_q[idx_q] <= temp_q;
                        temp_q        <= slot_q[idx_q];
                        idx_q         <= idx_q + IW'(1);
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data_rt_o = slot_q[0];
    assign bus.busy      = (state_q == INS);
    assign bus.count     = count_q;
    assign bus.full      = (count_q == FULL_CNT);
    assign bus.empty     = (count_q == '0);
    assign bus.drop      = drop_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_qq_tail.sv
// Self-checking bench for qq_tail: sorted-list model plus pop scoreboard.
module tb_qq_tail;
    localparam int W = 32;
    localparam int T = 4;
    localparam logic [W-1:0] MAXK = '1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    qq_tail_if #(.W(W), .T(T)) bus ();

    qq_tail #(.W(W), .T(T), .MAX_KEY(MAXK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    logic [W-1:0] model [$];
    logic [W-1:0] sb [$];
    logic ovf_m = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model_min();
        return (model.size() != 0) ? model[0] : MAXK;
    endfunction

    task automatic model_insert(input logic [W-1:0] key);
        int j;
        j = model.size();
        for (int k = 0; k < model.size(); k++) begin
            if (key < model[k]) begin
                j = k;
                break;
            end
        end
        model.insert(j, key);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check_val("idle_timeout", bus.busy, 0);
    endtask

    task automatic check_state(input string tag);
        check_val({tag, "_count"}, bus.count, model.size());
        check_val({tag, "_min"}, bus.data_rt_o, model_min());
        check_val({tag, "_empty"}, bus.empty, model.size() == 0);
        check_val({tag, "_full"}, bus.full, model.size() == T);
        check_val({tag, "_ovf"}, bus.overflow, ovf_m);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 2 * T + 4) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_enq(input logic [W-1:0] key);
        int  n;
        bit  was_full;
        wait_idle();
        was_full = (model.size() == T);
        @(negedge clk);
        bus.enq_i     = 1'b1;
        bus.data_lt_i = key;
        @(posedge clk); #1;
        bus.enq_i = 1'b0;
        if (key == MAXK) begin
            check_val("sentinel_busy", bus.busy, 0);
        end else if (was_full) begin
            ovf_m = 1'b1;
            check_val("drop_pulse", bus.drop, 1);
            check_val("drop_busy", bus.busy, 0);
            @(posedge clk); #1;
            check_val("drop_clear", bus.drop, 0);
        end else begin
            count_busy(n);
            check_val("busy_cycles", n, model.size() + 1);
            model_insert(key);
        end
        check_state("enq");
    endtask

    task automatic do_deq();
        wait_idle();
        @(negedge clk);
        bus.deq_i = 1'b1;
        sb.push_back(model_min());
        #1;
        check_val("deq_data", bus.data_rt_o, sb.pop_front());
        @(posedge clk); #1;
        bus.deq_i = 1'b0;
        if (model.size() != 0) void'(model.pop_front());
        check_state("deq");
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model.delete();
        sb.delete();
        ovf_m = 1'b0;
        #1;
        check_state("reset");
        check_val("reset_busy", bus.busy, 0);
        check_val("reset_drop", bus.drop, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.enq_i     = 1'b0;
        bus.deq_i     = 1'b0;
        bus.data_lt_i = '0;
        rst           = 1'b1;
        #1;

        // Reset values.
        do_reset();
        check_val("reset_data", bus.data_rt_o, 32'hFFFF_FFFF);

        // Sorted insert: busy lengths 1, 2, 3.
        do_enq(32'd30);
        do_enq(32'd10);
        do_enq(32'd20);
        check_val("sorted_min", bus.data_rt_o, 32'd10);
        check_val("sorted_count", bus.count, 3);

        // Drain: 10, 20, 30, then empty pop returns MAX.
        repeat (4) do_deq();
        check_val("drain_empty", bus.empty, 1);

        // Overflow: fill, push one more, drain.
        do_enq(32'd4);
        do_enq(32'd3);
        do_enq(32'd2);
        do_enq(32'd1);
        check_val("ovf_full", bus.full, 1);
        do_enq(32'd5);
        check_val("ovf_sticky", bus.overflow, 1);
        repeat (4) do_deq();
        check_val("ovf_after_drain", bus.overflow, 1);

        // Reset clears overflow.
        do_reset();

        // Simultaneous enq/deq with a tied key.
        do_enq(32'd7);
        wait_idle();
        @(negedge clk);
        bus.enq_i     = 1'b1;
        bus.deq_i     = 1'b1;
        bus.data_lt_i = 32'd7;
        @(posedge clk); #1;
        bus.enq_i = 1'b0;
        bus.deq_i = 1'b0;
        count_busy(n);
        check_val("simul_busy", n, 2);
        model_insert(32'd7);
        check_state("simul");
        check_val("simul_count", bus.count, 2);
        do_enq(MAXK);
        check_val("sentinel_count", bus.count, 2);

        // Reset mid-scan with three keys held.
        do_enq(32'd9);
        wait_idle();
        @(negedge clk);
        bus.enq_i     = 1'b1;
        bus.data_lt_i = 32'd0;
        @(posedge clk); #1;
        bus.enq_i = 1'b0;
        check_val("scan_busy1", bus.busy, 1);
        @(posedge clk); #1;
        check_val("scan_busy2", bus.busy, 1);
        rst = 1'b0;
        #1;
        check_val("midscan_count", bus.count, 0);
        check_val("midscan_busy", bus.busy, 0);
        check_val("midscan_data", bus.data_rt_o, 32'hFFFF_FFFF);
        model.delete();
        ovf_m = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_state("after_midscan");

        // Randomised rounds with small keys to provoke ties and drops.
        for (int r = 0; r < 4; r++) begin
            int nk;
            nk = $urandom_range(2, T + 1);
            for (int k = 0; k < nk; k++) begin
                do_enq(W'($urandom_range(0, 7)));
            end
            repeat (T + 1) do_deq();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/qq_tail.md
Name: qq_tail

Overview:
- Terminating responder at the right-hand end of a QuickQ node chain.
- Absorbs keys pushed out of the last node (enq/data_lt handshake) and keeps them in a small sorted register store.
- Continuously presents its smallest key on data_rt_o, so the last node can refill its final slot on a dequeue.
- Empty slots hold MAX_KEY, the same sentinel the nodes use, so a dequeue from an empty tail supplies MAX_KEY to the chain.

Parameters:
- W, 32, key width in bits.
- T, 4, number of tail slots (T >= 2).
- MAX_KEY, all ones ('1), empty-slot sentinel; never stored as a real key.
- Derived: CW = $clog2(T+1), count width; IW = $clog2(T), slot index width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; clears all state immediately while low.
- enq_i  input  1  push request from the last node; key on data_lt_i.
- data_lt_i  input  W  key being pushed.
- deq_i  input  1  pop request; the node samples data_rt_o in the same cycle.
- data_rt_o  output  W  current smallest key (slot[0]); MAX_KEY when empty.
- busy  output  1  high while an insertion scan is in progress.
- count  output  CW  number of valid keys held.
- full  output  1  count == T.
- empty  output  1  count == 0.
- drop  output  1  one-cycle pulse when a push is discarded because the tail is full.
- overflow  output  1  sticky flag, set on any drop; cleared only by reset.

Behaviour:
- Storage:
  - slot[0..T-1] kept ascending; valid keys occupy slot[0..count-1], all higher slots hold MAX_KEY.
  - Internal temp register (W bits) and idx register (IW bits).
- Reset (rst low, asynchronous):
  - All slots = MAX_KEY, temp = MAX_KEY, idx = 0, state = IDLE.
  - count = 0, data_rt_o = MAX_KEY, empty = 1, full = 0, busy = 0, drop = 0, overflow = 0.
  - Reset asserted mid-scan aborts the scan and discards the in-flight key.
- States: IDLE, INS.
- IDLE (busy = 0):
  - enq_i and deq_i both high: enq_i has priority; deq_i is ignored that cycle.
  - enq_i with data_lt_i == MAX_KEY: no-op; sentinel keys are never stored.
  - enq_i while full: contents unchanged, drop = 1 for that cycle, overflow <= 1, stay in IDLE.
  - enq_i otherwise: temp <= data_lt_i, idx <= 0, next = INS.
  - deq_i while not empty (and no enq_i): in one cycle slot[i] <= slot[i+1] for i < T-1, slot[T-1] <= MAX_KEY, count <= count-1. The popped value is the data_rt_o present during that cycle.
  - deq_i while empty: no state change; data_rt_o stays MAX_KEY.
- INS (busy = 1), one slot per cycle:
  - slot[idx] == MAX_KEY: slot[idx] <= temp, count <= count+1, next = IDLE.
  - else if temp < slot[idx] (unsigned, strict): slot[idx] <= temp, temp <= slot[idx], idx <= idx+1.
  - else: idx <= idx+1.
  - Strict compare means equal keys keep arrival order (FIFO among ties).
  - Entry is only permitted when not full, so the scan always ends at idx <= count. busy is high for exactly count_before+1 cycles.
  - enq_i and deq_i are ignored while busy; the chain must hold them off until busy = 0.
- Output timing:
  - data_rt_o, full, empty and count are derived from registers only; no combinational path from inputs.
  - The new minimum is visible the cycle after the update edge.

Test Plan:
- Reset: assert rst low for 2 cycles, then release -> data_rt_o = 32'hFFFFFFFF, count = 0, empty = 1, full = 0, busy = 0, overflow = 0.
- Sorted insert: enq 30, 10, 20 (W=32, T=4), each issued after busy falls -> busy high for 1, 2, 3 cycles respectively; then data_rt_o = 10, count = 3.
- Dequeue: continuing from the sorted-insert state, deq four times -> data_rt_o sampled 10, 20, 30, FFFFFFFF; final count = 0, empty = 1, and the 4th deq leaves state unchanged.
- Overflow: insert 4, 3, 2, 1, then enq 5 -> full = 1, drop pulses for one cycle, overflow = 1 and stays high; slots remain 1, 2, 3, 4; a following deq returns 1 with overflow still 1.
- Simultaneous and tie: holding key 7, assert enq_i(7) and deq_i in the same IDLE cycle -> enq wins, count = 2, data_rt_o = 7; enq of 32'hFFFFFFFF -> count unchanged.
- Reset mid-scan: with 3 keys held, start enq(0) and drive rst low during the 2nd INS cycle -> immediately count = 0, busy = 0, data_rt_o = FFFFFFFF.
